// File: rtl/io_port_sequencer.sv
// io_port_sequencer: sequences CPU IN/OUT requests onto one-hot selected I/O ports with ack/timeout handshake
module io_port_sequencer #(
  parameter int N = 4,
  parameter int M = 16,
  parameter int W = 4,
  parameter int TIMEOUT = 8,
  parameter logic [M-1:0] PORT_MASK = {M{1'b1}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic [N-1:0] addr,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] rdata,
  output logic [M-1:0] port_sel,
  output logic [W-1:0] port_wdata,
  output logic         port_wr,
  output logic         port_rd,
  input  logic [W-1:0] port_rdata,
  input  logic [M-1:0] port_ack
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state, state_d;
  logic [N-1:0] addr_q;
  logic we_q;
  logic [TW-1:0] timer;
  logic hit, tmo;
  always_comb begin
    hit = port_ack[addr_q];
    tmo = timer == TW'(TIMEOUT - 1);
    state_d = state;
    case (state)
      IDLE:    state_d = req ? (PORT_MASK[addr] ? SETUP : DONE) : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (hit || tmo) ? DONE : ACCESS;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      port_sel <= '0;
      port_wdata <= '0;
      port_wr <= 1'b0;
      port_rd <= 1'b0;
      addr_q <= '0;
      we_q <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_d;
      busy <= state_d != IDLE;
      done <= state_d == DONE;
      err <= state_d == DONE && (state == IDLE || !hit);
      port_sel <= state_d == SETUP ? M'(1) << addr : state_d == ACCESS ? port_sel : '0;
      port_wdata <= state_d == SETUP ? wdata : port_wdata;
      port_wr <= state_d == ACCESS && we_q;
      port_rd <= state_d == ACCESS && !we_q;
      timer <= (state == ACCESS && !hit && !tmo) ? timer + 1'b1 : '0;
      if (state == IDLE && req) begin
        addr_q <= addr;
        we_q <= we;
      end
      if (state == ACCESS && hit && !we_q) rdata <= port_rdata;
    end
  end
endmodule

// File: tb/tb_io_port_sequencer.sv
// tb_io_port_sequencer: directed and randomized transactions checked against a per-transaction timing model
module tb_io_port_sequencer;
  localparam int TO = 8;
  localparam logic [15:0] MASK = 16'hBDFF;
  logic clk = 0, reset = 1, req = 0, we = 0;
  logic [3:0] addr = 0, wdata = 0, rdata, port_wdata, port_rdata = 0;
  logic busy, done, err, port_wr, port_rd;
  logic [15:0] port_sel, port_ack = 0;
  int checks = 0, errors = 0;
  logic [3:0] rdata_m = 0;

  io_port_sequencer #(.N(4), .M(16), .W(4), .TIMEOUT(TO), .PORT_MASK(MASK)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .port_sel(port_sel),
    .port_wdata(port_wdata), .port_wr(port_wr), .port_rd(port_rd),
    .port_rdata(port_rdata), .port_ack(port_ack));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_sel"}, 32'(port_sel), 0);
    chk({tag, "_wdata"}, 32'(port_wdata), 0);
    chk({tag, "_strobes"}, 32'({port_wr, port_rd}), 0);
  endtask

  // ack_at: ACCESS cycle index (0-based) carrying the ack, -1 for none.
  task automatic run_txn(input logic [3:0] a, input bit w, input logic [3:0] d,
                         input logic [3:0] prd, input int ack_at, input bit wrong, input bit noise);
    logic [15:0] oh;
    logic [3:0] rd_old, rd_new, wb;
    bit masked, e, acc_c;
    int acc, dc;
    oh = 16'(1) << a;
    masked = !MASK[a];
    acc = ack_at >= 0 ? ack_at + 1 : TO;
    dc = masked ? 1 : 2 + acc;
    e = masked || ack_at < 0;
    rd_old = rdata_m;
    rd_new = (!e && !w) ? prd : rdata_m;
    wb = a ^ 4'($urandom_range(1, 15));
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    req = 1; we = w; addr = a; wdata = d; port_rdata = prd; port_ack = 0;
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      req = (noise && c <= dc) ? 1'($urandom_range(0, 1)) : 1'b0;
      addr = 4'($urandom); we = 1'($urandom); wdata = 4'($urandom);
      acc_c = !masked && c >= 2 && c < dc;
      chk("busy", 32'(busy), 32'(c <= dc));
      chk("done", 32'(done), 32'(c == dc));
      chk("err", 32'(err), 32'(c == dc && e));
      chk("sel", 32'(port_sel), (!masked && c < dc) ? 32'(oh) : 0);
      chk("wr", 32'(port_wr), 32'(acc_c && w));
      chk("rd", 32'(port_rd), 32'(acc_c && !w));
      if (!masked && c < dc) chk("pwdata", 32'(port_wdata), 32'(d));
      chk("rdata", 32'(rdata), c >= dc ? 32'(rd_new) : 32'(rd_old));
      port_ack = 0;
      if (acc_c && wrong) port_ack[wb] = 1'b1;
      if (acc_c && c - 2 == ack_at) port_ack[a] = 1'b1;
    end
    port_ack = 0;
    rdata_m = rd_new;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 0;
    run_txn(4'd3, 1, 4'hA, 4'h0, 0, 0, 0);
    run_txn(4'd15, 0, 4'h0, 4'h5, 2, 0, 0);
    run_txn(4'd7, 0, 4'h0, 4'hC, -1, 0, 0);
    run_txn(4'd2, 0, 4'h0, 4'h9, -1, 1, 0);
    run_txn(4'd2, 0, 4'h0, 4'h9, TO - 1, 1, 0);
    run_txn(4'd9, 1, 4'h6, 4'h0, 0, 0, 0);
    @(negedge clk);
    req = 1; we = 0; addr = 4'd1;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    chk("rst_pre_rd", 32'(port_rd), 1);
    reset = 1;
    @(negedge clk);
    chk_zero("midreset");
    reset = 0;
    rdata_m = 0;
    run_txn(4'd6, 0, 4'h3, 4'hE, 1, 0, 1);
    for (int i = 0; i < 40; i++)
      run_txn(4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
              int'($urandom_range(0, TO)) - 1, 1'($urandom), 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
